// File: rtl/riscv_pkg.sv
// Shared core package: issue-queue entry bundle and forwarding-bus indices.
// Imported by id_issue_queue; widths here set the stored entry layout.
package riscv_pkg;

    localparam int TAG_WIDTH    = 4;
    localparam int IQ_PAYLOAD_W = 64;

    localparam int IQ_FWD_EX  = 0;
    localparam int IQ_FWD_MEM = 1;
    localparam int IQ_FWD_WB  = 2;

    typedef struct packed {
        logic                          valid;
        logic                          exc;
        logic [IQ_PAYLOAD_W-1:0]       payload;
        logic [1:0]                    rs_ready;
        logic [1:0][TAG_WIDTH-1:0]     rs_tag;
        logic [1:0][31:0]              rs_data;
    } iq_entry_t;

endpackage

// File: rtl/iq_wakeup.sv
// One waiting operand compared against every forwarding bus.
// Ports: tag in; fwd_en/fwd_tag/fwd_data buses in; hit and data out.
module iq_wakeup #(
    parameter int TAG_WIDTH = 4,
    parameter int NUM_FWD   = 3
) (
    input  logic [TAG_WIDTH-1:0]         tag,
    input  logic [NUM_FWD-1:0]           fwd_en,
    input  logic [NUM_FWD*TAG_WIDTH-1:0] fwd_tag,
    input  logic [NUM_FWD*32-1:0]        fwd_data,
    output logic                         hit,
    output logic [31:0]                  data
);

    // Scan from the highest bus down so the lowest index ends up winning.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int b = NUM_FWD - 1; b >= 0; b--) begin
            if (fwd_en[b] && fwd_tag[b*TAG_WIDTH +: TAG_WIDTH] == tag) begin
                hit  = 1'b1;
                data = fwd_data[b*32 +: 32];
            end
        end
    end

endmodule

// File: rtl/id_issue_queue.sv
// In-order issue queue between decode and EX with tagged operand wakeup.
// Ports: clk, reset_n, flush; enq_* (decode side, valid/ready);
//   fwd_en/fwd_tag/fwd_data wakeup buses; iss_* (EX side, valid/ready);
//   count = occupancy. Macro IQ_ISSUE_BYPASS_EN adds an empty-queue
//   combinational enq->iss path.
module id_issue_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = IQ_PAYLOAD_W,
    parameter int TAG_WIDTH = riscv_pkg::TAG_WIDTH,
    parameter int NUM_FWD   = 3
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [PAYLOAD_W-1:0]         enq_payload,
    input  logic                         enq_exc,
    input  logic [1:0]                   enq_rs_ready,
    input  logic [2*TAG_WIDTH-1:0]       enq_rs_tag,
    input  logic [63:0]                  enq_rs_data,
    input  logic [NUM_FWD-1:0]           fwd_en,
    input  logic [NUM_FWD*TAG_WIDTH-1:0] fwd_tag,
    input  logic [NUM_FWD*32-1:0]        fwd_data,
    output logic                         iss_valid,
    input  logic                         iss_ready,
    output logic [PAYLOAD_W-1:0]         iss_payload,
    output logic                         iss_exc,
    output logic [63:0]                  iss_rs_data,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    iq_entry_t           q [DEPTH];
    iq_entry_t           enq_ent;
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [1:0]          wk_hit  [DEPTH];
    logic [1:0][31:0]    wk_data [DEPTH];
    logic [1:0]          en_hit;
    logic [1:0][31:0]    en_data;
    logic                head_rdy;
    logic                byp;
    logic                byp_fire;
    logic                iss_fire;
    logic                enq_fire;

    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        for (genvar s = 0; s < 2; s++) begin : g_op
            iq_wakeup #(.TAG_WIDTH(TAG_WIDTH), .NUM_FWD(NUM_FWD)) u_wk (
                .tag      (q[e].rs_tag[s]),
                .fwd_en   (fwd_en),
                .fwd_tag  (fwd_tag),
                .fwd_data (fwd_data),
                .hit      (wk_hit[e][s]),
                .data     (wk_data[e][s])
            );
        end
    end

    // Enqueue slot: a producer finishing this cycle is captured on entry.
    for (genvar s = 0; s < 2; s++) begin : g_enq
        iq_wakeup #(.TAG_WIDTH(TAG_WIDTH), .NUM_FWD(NUM_FWD)) u_wk (
            .tag      (enq_rs_tag[s*TAG_WIDTH +: TAG_WIDTH]),
            .fwd_en   (fwd_en),
            .fwd_tag  (fwd_tag),
            .fwd_data (fwd_data),
            .hit      (en_hit[s]),
            .data     (en_data[s])
        );
    end

    always_comb begin
        enq_ent         = '0;
        enq_ent.valid   = 1'b1;
        enq_ent.exc     = enq_exc;
        enq_ent.payload = enq_payload;
        enq_ent.rs_tag  = enq_rs_tag;
        for (int s = 0; s < 2; s++) begin
            enq_ent.rs_ready[s] = enq_rs_ready[s] | en_hit[s];
            enq_ent.rs_data[s]  = enq_rs_ready[s] ? enq_rs_data[s*32 +: 32]
                                                  : en_data[s];
        end
    end

    assign head_rdy  = q[rd_ptr].valid & (q[rd_ptr].exc | (&q[rd_ptr].rs_ready));
    assign enq_ready = count < CW'(DEPTH);

`ifdef IQ_ISSUE_BYPASS_EN
    assign byp = (count == '0) & enq_valid & ~flush
               & (enq_exc | (&enq_ent.rs_ready));
`else
    assign byp = 1'b0;
`endif

    assign iss_valid   = ~flush & (head_rdy | byp);
    assign iss_payload = byp ? enq_payload : q[rd_ptr].payload;
    assign iss_exc     = byp ? enq_exc : q[rd_ptr].exc;
    assign iss_rs_data = byp ? enq_ent.rs_data : q[rd_ptr].rs_data;

    // A bypassed entry is consumed directly and never written.
    assign byp_fire = byp & iss_ready;
    assign iss_fire = ~flush & ~byp & head_rdy & iss_ready;
    assign enq_fire = enq_valid & enq_ready & ~flush & ~byp_fire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int e = 0; e < DEPTH; e++) q[e] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            for (int e = 0; e < DEPTH; e++) q[e].valid <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                for (int s = 0; s < 2; s++) begin
                    if (q[e].valid && !q[e].rs_ready[s] && wk_hit[e][s]) begin
                        q[e].rs_ready[s] <= 1'b1;
                        q[e].rs_data[s]  <= wk_data[e][s];
                    end
                end
            end
            if (iss_fire) begin
                q[rd_ptr].valid <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
            if (enq_fire) begin
                q[wr_ptr] <= enq_ent;
                wr_ptr    <= wr_ptr + 1'b1;
            end
            count <= count + CW'(enq_fire) - CW'(iss_fire);
        end
    end

endmodule

// File: tb/tb_id_issue_queue.sv
// Self-checking bench for id_issue_queue: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_id_issue_queue;

    localparam int DEPTH = 4;
    localparam int TW    = 4;
    localparam int NF    = 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            flush;
    logic            enq_valid;
    logic            enq_ready;
    logic [63:0]     enq_payload;
    logic            enq_exc;
    logic [1:0]      enq_rs_ready;
    logic [2*TW-1:0] enq_rs_tag;
    logic [63:0]     enq_rs_data;
    logic [NF-1:0]   fwd_en;
    logic [NF*TW-1:0] fwd_tag;
    logic [NF*32-1:0] fwd_data;
    logic            iss_valid;
    logic            iss_ready;
    logic [63:0]     iss_payload;
    logic            iss_exc;
    logic [63:0]     iss_rs_data;
    logic [2:0]      count;

    id_issue_queue #(.DEPTH(DEPTH), .PAYLOAD_W(64), .TAG_WIDTH(TW), .NUM_FWD(NF)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .enq_valid    (enq_valid),
        .enq_ready    (enq_ready),
        .enq_payload  (enq_payload),
        .enq_exc      (enq_exc),
        .enq_rs_ready (enq_rs_ready),
        .enq_rs_tag   (enq_rs_tag),
        .enq_rs_data  (enq_rs_data),
        .fwd_en       (fwd_en),
        .fwd_tag      (fwd_tag),
        .fwd_data     (fwd_data),
        .iss_valid    (iss_valid),
        .iss_ready    (iss_ready),
        .iss_payload  (iss_payload),
        .iss_exc      (iss_exc),
        .iss_rs_data  (iss_rs_data),
        .count        (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]       pl;
        logic              exc;
        logic [1:0]        rdy;
        logic [1:0][TW-1:0] tag;
        logic [1:0][31:0]  dat;
    } ment_t;

    ment_t mq[$];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // First enabled bus (lowest index) carrying the tag supplies the data.
    function automatic void fwd_lookup(input logic [TW-1:0] t,
                                       output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        for (int b = 0; b < NF; b++) begin
            if (!h && fwd_en[b] && fwd_tag[b*TW +: TW] == t) begin
                h = 1'b1;
                d = fwd_data[b*32 +: 32];
            end
        end
    endfunction

    function automatic ment_t mk_enq();
        ment_t e;
        logic h;
        logic [31:0] d;
        e.pl  = enq_payload;
        e.exc = enq_exc;
        e.tag = enq_rs_tag;
        for (int s = 0; s < 2; s++) begin
            fwd_lookup(enq_rs_tag[s*TW +: TW], h, d);
            e.rdy[s] = enq_rs_ready[s] | h;
            e.dat[s] = enq_rs_ready[s] ? enq_rs_data[s*32 +: 32] : d;
        end
        return e;
    endfunction

    task automatic idle();
        flush        = 1'b0;
        enq_valid    = 1'b0;
        enq_payload  = '0;
        enq_exc      = 1'b0;
        enq_rs_ready = 2'b00;
        enq_rs_tag   = '0;
        enq_rs_data  = '0;
        fwd_en       = '0;
        fwd_tag      = '0;
        fwd_data     = '0;
        iss_ready    = 1'b0;
    endtask

    // Called at a falling edge with inputs driven: check, advance model, clock.
    task automatic step();
        ment_t e, h;
        bit byp, exp_v;
        int sz;
        logic [63:0] m;
        logic hit;
        logic [31:0] d;
        #1;
        sz  = mq.size();
        e   = mk_enq();
        byp = 1'b0;
`ifdef IQ_ISSUE_BYPASS_EN
        byp = (sz == 0) && enq_valid && !flush && (enq_exc || e.rdy == 2'b11);
`endif
        exp_v = !flush && (byp || (sz > 0 && (mq[0].exc || mq[0].rdy == 2'b11)));
        check("count", 64'(count), 64'(sz));
        check("enq_ready", 64'(enq_ready), 64'(sz < DEPTH));
        check("iss_valid", 64'(iss_valid), 64'(exp_v));
        if (exp_v) begin
            h = byp ? e : mq[0];
            m = {{32{h.rdy[1]}}, {32{h.rdy[0]}}};
            check("iss_payload", iss_payload, h.pl);
            check("iss_exc", 64'(iss_exc), 64'(h.exc));
            check("iss_rs_data", iss_rs_data & m, h.dat & m);
        end
        if (flush) begin
            mq.delete();
        end else begin
            foreach (mq[i]) begin
                for (int s = 0; s < 2; s++) begin
                    if (!mq[i].rdy[s]) begin
                        fwd_lookup(mq[i].tag[s], hit, d);
                        if (hit) begin
                            mq[i].rdy[s] = 1'b1;
                            mq[i].dat[s] = d;
                        end
                    end
                end
            end
            if (exp_v && iss_ready && !byp) void'(mq.pop_front());
            if (enq_valid && sz < DEPTH && !(byp && iss_ready)) mq.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_iss_valid", 64'(iss_valid), 64'd0);
        check("rst_enq_ready", 64'(enq_ready), 64'd1);
        mq.delete();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic enq_ready_op(input logic [63:0] pl);
        enq_valid    = 1'b1;
        enq_payload  = pl;
        enq_rs_ready = 2'b11;
        enq_rs_data  = {$urandom, $urandom};
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        @(negedge clk);
        do_reset();

        // Fill to full with a fifth offer, then drain in order.
        for (int i = 0; i < 5; i++) begin
            enq_ready_op(64'h100 + 64'(i));
            step();
        end
        check("t1_full", 64'(count), 64'd4);
        idle();
        iss_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("t1_empty", 64'(count), 64'd0);

        // Head rs1 waits on tag 3; mem bus delivers it.
        idle();
        enq_valid    = 1'b1;
        enq_payload  = 64'hA2;
        enq_rs_ready = 2'b10;
        enq_rs_tag   = 8'h03;
        step();
        idle();
        iss_ready = 1'b1;
        step();
        fwd_en   = 3'b010;
        fwd_tag  = 12'h030;
        fwd_data = {32'h0, 32'hDEADBEEF, 32'h0};
        step();
        idle();
        iss_ready = 1'b1;
        #1;
        check("t2_valid", 64'(iss_valid), 64'd1);
        check("t2_rs1", 64'(iss_rs_data[31:0]), 64'hDEADBEEF);
        step();

        // rs2 woken by wb bus during the enqueue cycle itself.
        idle();
        enq_valid    = 1'b1;
        enq_payload  = 64'hA3;
        enq_rs_ready = 2'b01;
        enq_rs_tag   = 8'h50;
        fwd_en       = 3'b100;
        fwd_tag      = 12'h500;
        fwd_data     = {32'h1234, 64'h0};
        step();
        idle();
        iss_ready = 1'b1;
        #1;
        check("t3_valid", 64'(iss_valid), 64'd1);
        check("t3_rs2", 64'(iss_rs_data[63:32]), 64'h1234);
        step();

        // Stalled head blocks a ready younger entry.
        idle();
        enq_valid    = 1'b1;
        enq_payload  = 64'hA4;
        enq_rs_ready = 2'b10;
        enq_rs_tag   = 8'h07;
        step();
        for (int i = 0; i < 3; i++) begin
            enq_ready_op(64'hB0 + 64'(i));
            step();
        end
        idle();
        iss_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("t4_stall", 64'(count), 64'd4);
        fwd_en  = 3'b001;
        fwd_tag = 12'h007;
        fwd_data = {64'h0, 32'h77};
        step();
        idle();
        iss_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Flush wins over a concurrent enqueue and issue.
        for (int i = 0; i < 2; i++) begin
            enq_ready_op(64'hC0 + 64'(i));
            step();
        end
        enq_ready_op(64'hC9);
        flush     = 1'b1;
        iss_ready = 1'b1;
        step();
        idle();
        #1;
        check("t5_count", 64'(count), 64'd0);
        check("t5_valid", 64'(iss_valid), 64'd0);
        for (int i = 0; i < 2; i++) begin
            enq_ready_op(64'hD0 + 64'(i));
            step();
        end
        do_reset();

        // Exception entry issues without operands.
        idle();
        enq_valid   = 1'b1;
        enq_payload = 64'hE6;
        enq_exc     = 1'b1;
        enq_rs_tag  = 8'hFF;
        iss_ready   = 1'b1;
`ifdef IQ_ISSUE_BYPASS_EN
        #1;
        check("t6_byp_valid", 64'(iss_valid), 64'd1);
`endif
        step();
        idle();
        iss_ready = 1'b1;
`ifndef IQ_ISSUE_BYPASS_EN
        #1;
        check("t6_valid", 64'(iss_valid), 64'd1);
        check("t6_exc", 64'(iss_exc), 64'd1);
`endif
        step();

        // Random traffic with small tag space to exercise multi-bus hits.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                flush        = ($urandom_range(0, 31) == 0);
                enq_valid    = $urandom_range(0, 1);
                enq_payload  = {$urandom, $urandom};
                enq_exc      = ($urandom_range(0, 7) == 0);
                enq_rs_ready = 2'($urandom);
                enq_rs_tag   = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
                enq_rs_data  = {$urandom, $urandom};
                fwd_en       = 3'($urandom);
                for (int b = 0; b < NF; b++) begin
                    fwd_tag[b*TW +: TW]  = 4'($urandom_range(0, 5));
                    fwd_data[b*32 +: 32] = $urandom;
                end
                iss_ready = ($urandom_range(0, 9) < 7);
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
